// File: rtl/axi4_pkg.sv
// AXI4 link types shared by the register slice and its skid buffers.
// Optional stall counters in axi4_reg_slice are enabled with AXI4_REG_SLICE_PERF_EN.
package axi4_pkg;

  localparam int AXI4_NUM_CHANNELS = 5;
  localparam int CH_AW = 0;
  localparam int CH_W  = 1;
  localparam int CH_B  = 2;
  localparam int CH_AR = 3;
  localparam int CH_R  = 4;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic ACLK;
    logic ARESETn;
  } common;

  typedef struct packed {
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
  } aw_m;
  typedef struct packed { logic AWREADY; } aw_s;

  typedef struct packed {
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
  } w_m;
  typedef struct packed { logic WREADY; } w_s;

  typedef struct packed { logic BREADY; } b_m;
  typedef struct packed {
    logic [3:0] BID;
    logic [1:0] BRESP;
    logic       BVALID;
  } b_s;

  typedef struct packed {
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
  } ar_m;
  typedef struct packed { logic ARREADY; } ar_s;

  typedef struct packed { logic RREADY; } r_m;
  typedef struct packed {
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
  } r_s;

  // Payload-only views captured by the skid buffers.
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_pl_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_pl_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_pl_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_pl_t;

endpackage

// File: rtl/axi4_skid_buf.sv
// Two-entry skid buffer for one AXI channel; EN=0 degenerates to wires.
// Handshake: a beat moves on an edge where valid & ready are both 1; valid never drops without a pop.
module axi4_skid_buf
  import axi4_pkg::*;
#(
  parameter type T  = logic,
  parameter int  EN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  T            i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output T            o_data,
  output skid_state_e o_state
);

  if (EN != 0) begin : g_reg
    skid_state_e r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    T            r_out;
    T            r_skid;
    logic        w_push;
    logic        w_pop;

    assign w_push = i_valid & r_in_ready;
    assign w_pop  = r_out_valid & i_ready;

    // in_ready defaults high each cycle and is pulled low only while both entries are full.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_state     <= SKID_EMPTY;
        r_in_ready  <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        r_in_ready <= 1'b1;
        unique case (r_state)
          SKID_EMPTY: begin
            if (w_push) begin
              r_out       <= i_data;
              r_out_valid <= 1'b1;
              r_state     <= SKID_ONE;
            end
          end
          SKID_ONE: begin
            if (w_push && !w_pop) begin
              r_skid     <= i_data;
              r_in_ready <= 1'b0;
              r_state    <= SKID_TWO;
            end else if (!w_push && w_pop) begin
              r_out_valid <= 1'b0;
              r_state     <= SKID_EMPTY;
            end else if (w_push) begin
              r_out <= i_data;
            end
          end
          SKID_TWO: begin
            if (w_pop) begin
              r_out   <= r_skid;
              r_state <= SKID_ONE;
            end else begin
              r_in_ready <= 1'b0;
            end
          end
          default: r_state <= SKID_EMPTY;
        endcase
      end
    end

    assign o_ready = r_in_ready;
    assign o_valid = r_out_valid;
    assign o_data  = r_out;
    assign o_state = r_state;
  end else begin : g_wire
    logic w_unused_clk;
    assign w_unused_clk = i_clk ^ i_rst_n;
    assign o_ready      = i_ready;
    assign o_valid      = i_valid;
    assign o_data       = i_data;
    assign o_state      = SKID_EMPTY;
  end

endmodule

// File: rtl/axi4_reg_slice.sv
// AXI4 register slice: one skid buffer per channel, payload/IDs passed unchanged.
// Define AXI4_REG_SLICE_PERF_EN to add per-channel stall counters (PERF_STALL_CNT).
module axi4_reg_slice
  import axi4_pkg::*;
#(
  parameter int AW_EN = 1,
  parameter int W_EN  = 1,
  parameter int B_EN  = 1,
  parameter int AR_EN = 1,
  parameter int R_EN  = 1
) (
  input  common AXI_COMMON,
  input  aw_m   UP_AW_M,
  output aw_s   UP_AW_S,
  input  w_m    UP_W_M,
  output w_s    UP_W_S,
  input  b_m    UP_B_M,
  output b_s    UP_B_S,
  input  ar_m   UP_AR_M,
  output ar_s   UP_AR_S,
  input  r_m    UP_R_M,
  output r_s    UP_R_S,
  output aw_m   DN_AW_M,
  input  aw_s   DN_AW_S,
  output w_m    DN_W_M,
  input  w_s    DN_W_S,
  output ar_m   DN_AR_M,
  input  ar_s   DN_AR_S,
  output b_m    DN_B_M,
  input  b_s    DN_B_S,
  output r_m    DN_R_M,
  input  r_s    DN_R_S,
  output logic [AXI4_NUM_CHANNELS-1:0][1:0] o_dbg_state
`ifdef AXI4_REG_SLICE_PERF_EN
  ,
  output logic [AXI4_NUM_CHANNELS-1:0][31:0] PERF_STALL_CNT
`endif
);

  logic w_clk;
  logic w_rst_n;
  assign w_clk   = AXI_COMMON.ACLK;
  assign w_rst_n = AXI_COMMON.ARESETn;

  ax_pl_t w_aw_in, w_aw_out, w_ar_in, w_ar_out;
  w_pl_t  w_w_in, w_w_out;
  b_pl_t  w_b_in, w_b_out;
  r_pl_t  w_r_in, w_r_out;
  logic [AXI4_NUM_CHANNELS-1:0] w_out_valid, w_out_ready, w_in_ready;
  skid_state_e w_st_aw, w_st_w, w_st_b, w_st_ar, w_st_r;

  assign w_aw_in = '{id: UP_AW_M.AWID, addr: UP_AW_M.AWADDR, len: UP_AW_M.AWLEN,
                     size: UP_AW_M.AWSIZE, burst: UP_AW_M.AWBURST};
  assign w_ar_in = '{id: UP_AR_M.ARID, addr: UP_AR_M.ARADDR, len: UP_AR_M.ARLEN,
                     size: UP_AR_M.ARSIZE, burst: UP_AR_M.ARBURST};
  assign w_w_in  = '{data: UP_W_M.WDATA, strb: UP_W_M.WSTRB, last: UP_W_M.WLAST};
  assign w_b_in  = '{id: DN_B_S.BID, resp: DN_B_S.BRESP};
  assign w_r_in  = '{id: DN_R_S.RID, data: DN_R_S.RDATA, resp: DN_R_S.RRESP, last: DN_R_S.RLAST};

  assign w_out_ready = {UP_R_M.RREADY, DN_AR_S.ARREADY, UP_B_M.BREADY, DN_W_S.WREADY, DN_AW_S.AWREADY};

  axi4_skid_buf #(.T(ax_pl_t), .EN(AW_EN)) u_aw (
    .i_clk(w_clk), .i_rst_n(w_rst_n),
    .i_valid(UP_AW_M.AWVALID), .o_ready(w_in_ready[CH_AW]), .i_data(w_aw_in),
    .o_valid(w_out_valid[CH_AW]), .i_ready(w_out_ready[CH_AW]), .o_data(w_aw_out),
    .o_state(w_st_aw));

  axi4_skid_buf #(.T(w_pl_t), .EN(W_EN)) u_w (
    .i_clk(w_clk), .i_rst_n(w_rst_n),
    .i_valid(UP_W_M.WVALID), .o_ready(w_in_ready[CH_W]), .i_data(w_w_in),
    .o_valid(w_out_valid[CH_W]), .i_ready(w_out_ready[CH_W]), .o_data(w_w_out),
    .o_state(w_st_w));

  axi4_skid_buf #(.T(b_pl_t), .EN(B_EN)) u_b (
    .i_clk(w_clk), .i_rst_n(w_rst_n),
    .i_valid(DN_B_S.BVALID), .o_ready(w_in_ready[CH_B]), .i_data(w_b_in),
    .o_valid(w_out_valid[CH_B]), .i_ready(w_out_ready[CH_B]), .o_data(w_b_out),
    .o_state(w_st_b));

  axi4_skid_buf #(.T(ax_pl_t), .EN(AR_EN)) u_ar (
    .i_clk(w_clk), .i_rst_n(w_rst_n),
    .i_valid(UP_AR_M.ARVALID), .o_ready(w_in_ready[CH_AR]), .i_data(w_ar_in),
    .o_valid(w_out_valid[CH_AR]), .i_ready(w_out_ready[CH_AR]), .o_data(w_ar_out),
    .o_state(w_st_ar));

  axi4_skid_buf #(.T(r_pl_t), .EN(R_EN)) u_r (
    .i_clk(w_clk), .i_rst_n(w_rst_n),
    .i_valid(DN_R_S.RVALID), .o_ready(w_in_ready[CH_R]), .i_data(w_r_in),
    .o_valid(w_out_valid[CH_R]), .i_ready(w_out_ready[CH_R]), .o_data(w_r_out),
    .o_state(w_st_r));

  assign UP_AW_S = '{AWREADY: w_in_ready[CH_AW]};
  assign UP_W_S  = '{WREADY: w_in_ready[CH_W]};
  assign UP_AR_S = '{ARREADY: w_in_ready[CH_AR]};
  assign DN_B_M  = '{BREADY: w_in_ready[CH_B]};
  assign DN_R_M  = '{RREADY: w_in_ready[CH_R]};

  assign DN_AW_M = '{AWID: w_aw_out.id, AWADDR: w_aw_out.addr, AWLEN: w_aw_out.len,
                     AWSIZE: w_aw_out.size, AWBURST: w_aw_out.burst, AWVALID: w_out_valid[CH_AW]};
  assign DN_AR_M = '{ARID: w_ar_out.id, ARADDR: w_ar_out.addr, ARLEN: w_ar_out.len,
                     ARSIZE: w_ar_out.size, ARBURST: w_ar_out.burst, ARVALID: w_out_valid[CH_AR]};
  assign DN_W_M  = '{WDATA: w_w_out.data, WSTRB: w_w_out.strb, WLAST: w_w_out.last,
                     WVALID: w_out_valid[CH_W]};
  assign UP_B_S  = '{BID: w_b_out.id, BRESP: w_b_out.resp, BVALID: w_out_valid[CH_B]};
  assign UP_R_S  = '{RID: w_r_out.id, RDATA: w_r_out.data, RRESP: w_r_out.resp,
                     RLAST: w_r_out.last, RVALID: w_out_valid[CH_R]};

  assign o_dbg_state = {w_st_r, w_st_ar, w_st_b, w_st_w, w_st_aw};

`ifdef AXI4_REG_SLICE_PERF_EN
  logic [AXI4_NUM_CHANNELS-1:0][31:0] r_stall_cnt;

  // A stall is a cycle where the channel output is offered but not taken.
  always_ff @(posedge w_clk) begin
    for (int c = 0; c < AXI4_NUM_CHANNELS; c++) begin
      if (!w_rst_n) begin
        r_stall_cnt[c] <= '0;
      end else if (w_out_valid[c] && !w_out_ready[c] && (r_stall_cnt[c] != 32'hFFFF_FFFF)) begin
        r_stall_cnt[c] <= r_stall_cnt[c] + 32'd1;
      end
    end
  end

  assign PERF_STALL_CNT = r_stall_cnt;
`else
  logic w_perf_unused;
  assign w_perf_unused = ^{w_out_valid, w_out_ready};
`endif

endmodule

// File: tb/tb_axi4_reg_slice.sv
// Directed bench for axi4_reg_slice: vector table for W backpressure plus hand sequences.
// Also checks the W stall counter when AXI4_REG_SLICE_PERF_EN is defined.
module tb_axi4_reg_slice;
  import axi4_pkg::*;

  localparam int AR_W = 44;

  logic clk;
  logic rst_n;
  common axi_common;

  aw_m up_aw_m, dn_aw_m, pt_up_aw_m, pt_dn_aw_m;
  aw_s up_aw_s, dn_aw_s, pt_up_aw_s, pt_dn_aw_s;
  w_m  up_w_m,  dn_w_m,  pt_up_w_m,  pt_dn_w_m;
  w_s  up_w_s,  dn_w_s,  pt_up_w_s,  pt_dn_w_s;
  b_m  up_b_m,  dn_b_m,  pt_up_b_m,  pt_dn_b_m;
  b_s  up_b_s,  dn_b_s,  pt_up_b_s,  pt_dn_b_s;
  ar_m up_ar_m, dn_ar_m, pt_up_ar_m, pt_dn_ar_m;
  ar_s up_ar_s, dn_ar_s, pt_up_ar_s, pt_dn_ar_s;
  r_m  up_r_m,  dn_r_m,  pt_up_r_m,  pt_dn_r_m;
  r_s  up_r_s,  dn_r_s,  pt_up_r_s,  pt_dn_r_s;
  logic [AXI4_NUM_CHANNELS-1:0][1:0] dbg_state, pt_dbg_state;
`ifdef AXI4_REG_SLICE_PERF_EN
  logic [AXI4_NUM_CHANNELS-1:0][31:0] perf_cnt, pt_perf_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [AR_W-1:0] exp_q[$];

  typedef struct {
    logic        wvalid;
    logic [31:0] wdata;
    logic        wlast;
    logic        dn_wready;
    logic        exp_wready;
    logic        exp_dn_valid;
    logic [31:0] exp_data;
    logic        exp_last;
  } w_vec_t;
  w_vec_t w_tab[8];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign axi_common = '{ACLK: clk, ARESETn: rst_n};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  axi4_reg_slice u_dut (
    .AXI_COMMON(axi_common),
    .UP_AW_M(up_aw_m), .UP_AW_S(up_aw_s), .UP_W_M(up_w_m), .UP_W_S(up_w_s),
    .UP_B_M(up_b_m), .UP_B_S(up_b_s), .UP_AR_M(up_ar_m), .UP_AR_S(up_ar_s),
    .UP_R_M(up_r_m), .UP_R_S(up_r_s),
    .DN_AW_M(dn_aw_m), .DN_AW_S(dn_aw_s), .DN_W_M(dn_w_m), .DN_W_S(dn_w_s),
    .DN_AR_M(dn_ar_m), .DN_AR_S(dn_ar_s), .DN_B_M(dn_b_m), .DN_B_S(dn_b_s),
    .DN_R_M(dn_r_m), .DN_R_S(dn_r_s),
    .o_dbg_state(dbg_state)
`ifdef AXI4_REG_SLICE_PERF_EN
    , .PERF_STALL_CNT(perf_cnt)
`endif
  );

  axi4_reg_slice #(.AW_EN(0)) u_dut_pt (
    .AXI_COMMON(axi_common),
    .UP_AW_M(pt_up_aw_m), .UP_AW_S(pt_up_aw_s), .UP_W_M(pt_up_w_m), .UP_W_S(pt_up_w_s),
    .UP_B_M(pt_up_b_m), .UP_B_S(pt_up_b_s), .UP_AR_M(pt_up_ar_m), .UP_AR_S(pt_up_ar_s),
    .UP_R_M(pt_up_r_m), .UP_R_S(pt_up_r_s),
    .DN_AW_M(pt_dn_aw_m), .DN_AW_S(pt_dn_aw_s), .DN_W_M(pt_dn_w_m), .DN_W_S(pt_dn_w_s),
    .DN_AR_M(pt_dn_ar_m), .DN_AR_S(pt_dn_ar_s), .DN_B_M(pt_dn_b_m), .DN_B_S(pt_dn_b_s),
    .DN_R_M(pt_dn_r_m), .DN_R_S(pt_dn_r_s),
    .o_dbg_state(pt_dbg_state)
`ifdef AXI4_REG_SLICE_PERF_EN
    , .PERF_STALL_CNT(pt_perf_cnt)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] all_valids();
    return {dn_aw_m.AWVALID, dn_w_m.WVALID, dn_ar_m.ARVALID, up_b_s.BVALID, up_r_s.RVALID};
  endfunction

  function automatic logic [4:0] all_readys();
    return {up_aw_s.AWREADY, up_w_s.WREADY, up_ar_s.ARREADY, dn_b_m.BREADY, dn_r_m.RREADY};
  endfunction

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    w_tab[0] = '{1'b1, 32'hA000_0000, 1'b0, 1'b0,  1'b1, 1'b0, 32'h0,         1'b0};
    w_tab[1] = '{1'b1, 32'hA000_0001, 1'b0, 1'b0,  1'b1, 1'b1, 32'hA000_0000, 1'b0};
    w_tab[2] = '{1'b1, 32'hA000_0002, 1'b1, 1'b0,  1'b0, 1'b1, 32'hA000_0000, 1'b0};
    w_tab[3] = '{1'b1, 32'hA000_0002, 1'b1, 1'b0,  1'b0, 1'b1, 32'hA000_0000, 1'b0};
    w_tab[4] = '{1'b1, 32'hA000_0002, 1'b1, 1'b1,  1'b0, 1'b1, 32'hA000_0000, 1'b0};
    w_tab[5] = '{1'b1, 32'hA000_0002, 1'b1, 1'b1,  1'b1, 1'b1, 32'hA000_0001, 1'b0};
    w_tab[6] = '{1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 32'hA000_0002, 1'b1};
    w_tab[7] = '{1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b0, 32'h0,         1'b0};

    rst_n = 1'b0;
    up_aw_m = '0; dn_aw_s = '0; up_w_m = '0; dn_w_s = '0; up_b_m = '0; dn_b_s = '0;
    up_ar_m = '0; dn_ar_s = '0; up_r_m = '0; dn_r_s = '0;
    pt_up_aw_m = '0; pt_dn_aw_s = '0; pt_up_w_m = '0; pt_dn_w_s = '0; pt_up_b_m = '0;
    pt_dn_b_s = '0; pt_up_ar_m = '0; pt_dn_ar_s = '0; pt_up_r_m = '0; pt_dn_r_s = '0;

    // Reset held for 3 edges while AWVALID is offered.
    up_aw_m.AWVALID = 1'b1;
    up_aw_m.AWADDR  = 32'h0000_0100;
    up_aw_m.AWID    = 4'h3;
    dn_aw_s.AWREADY = 1'b1;
    up_b_m.BREADY   = 1'b1;
    up_r_m.RREADY   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      #3;
      check("rst_valids", 64'(all_valids()), 64'h0);
      check("rst_readys", 64'(all_readys()), 64'h0);
    end
    rst_n = 1'b1;
    next_cycle();
    #3;
    check("rel_readys", 64'(all_readys()), 64'h1F);
    check("rel_dn_awvalid", 64'(dn_aw_m.AWVALID), 64'h0);
    next_cycle();
    up_aw_m.AWVALID = 1'b0;
    #3;
    check("aw_dn_valid", 64'(dn_aw_m.AWVALID), 64'h1);
    check("aw_dn_addr", 64'(dn_aw_m.AWADDR), 64'h100);
    check("aw_dn_id", 64'(dn_aw_m.AWID), 64'h3);
    next_cycle();
    #3;
    check("aw_drained", 64'(dn_aw_m.AWVALID), 64'h0);

    // W backpressure table: 2 beats absorbed, third waits, then drains in order.
    up_w_m.WSTRB = 4'hF;
    for (int r = 0; r < 8; r++) begin
      next_cycle();
      up_w_m.WVALID  = w_tab[r].wvalid;
      up_w_m.WDATA   = w_tab[r].wdata;
      up_w_m.WLAST   = w_tab[r].wlast;
      dn_w_s.WREADY  = w_tab[r].dn_wready;
      #3;
      check($sformatf("w_ready[%0d]", r), 64'(up_w_s.WREADY), 64'(w_tab[r].exp_wready));
      check($sformatf("w_dn_valid[%0d]", r), 64'(dn_w_m.WVALID), 64'(w_tab[r].exp_dn_valid));
      if (w_tab[r].exp_dn_valid) begin
        check($sformatf("w_dn_data[%0d]", r), 64'({dn_w_m.WDATA, dn_w_m.WLAST, dn_w_m.WSTRB}),
              64'({w_tab[r].exp_data, w_tab[r].exp_last, 4'hF}));
      end
    end
`ifdef AXI4_REG_SLICE_PERF_EN
    check("perf_w_stalls", 64'(perf_cnt[CH_W]), 64'd3);
`endif

    // AR streaming: 16 back-to-back beats, each visible downstream one cycle later.
    dn_ar_s.ARREADY = 1'b1;
    for (int i = 0; i < 18; i++) begin
      next_cycle();
      if (i < 16) begin
        up_ar_m.ARVALID = 1'b1;
        up_ar_m.ARID    = 4'(i);
        up_ar_m.ARADDR  = 32'h2000_0000 + 32'(i * 16);
        up_ar_m.ARLEN   = 8'(i + 1);
        exp_q.push_back({4'(i), 32'h2000_0000 + 32'(i * 16), 8'(i + 1)});
      end else begin
        up_ar_m.ARVALID = 1'b0;
      end
      #3;
      if (i < 16) check($sformatf("ar_up_ready[%0d]", i), 64'(up_ar_s.ARREADY), 64'h1);
      check($sformatf("ar_dn_valid[%0d]", i), 64'(dn_ar_m.ARVALID), 64'((i >= 1) && (i <= 16)));
      if (dn_ar_m.ARVALID && exp_q.size() > 0) begin
        check($sformatf("ar_dn_beat[%0d]", i),
              64'({dn_ar_m.ARID, dn_ar_m.ARADDR, dn_ar_m.ARLEN}), 64'(exp_q.pop_front()));
      end
    end
    check("ar_all_delivered", 64'(exp_q.size()), 64'h0);

    // R: push coincides with pop while in ONE; output entry is replaced.
    next_cycle();
    dn_r_s = '{RID: 4'h5, RDATA: 32'hCAFE_0001, RRESP: 2'b00, RLAST: 1'b0, RVALID: 1'b1};
    #3;
    check("r_dn_ready", 64'(dn_r_m.RREADY), 64'h1);
    check("r_up_valid0", 64'(up_r_s.RVALID), 64'h0);
    next_cycle();
    dn_r_s = '{RID: 4'h6, RDATA: 32'hCAFE_0002, RRESP: 2'b01, RLAST: 1'b1, RVALID: 1'b1};
    #3;
    check("r_first_beat", 64'({up_r_s.RVALID, up_r_s.RID, up_r_s.RDATA}), {27'h0, 1'b1, 4'h5, 32'hCAFE_0001});
    check("r_state_one_a", 64'(dbg_state[CH_R]), 64'(SKID_ONE));
    next_cycle();
    dn_r_s.RVALID = 1'b0;
    #3;
    check("r_second_beat", 64'({up_r_s.RVALID, up_r_s.RID, up_r_s.RDATA, up_r_s.RRESP, up_r_s.RLAST}),
          {24'h0, 1'b1, 4'h6, 32'hCAFE_0002, 2'b01, 1'b1});
    check("r_state_one_b", 64'(dbg_state[CH_R]), 64'(SKID_ONE));
    next_cycle();
    #3;
    check("r_drained", 64'(up_r_s.RVALID), 64'h0);
    check("r_state_empty", 64'(dbg_state[CH_R]), 64'(SKID_EMPTY));

    // B: two beats buffered, then reset discards them.
    up_b_m.BREADY = 1'b0;
    next_cycle();
    dn_b_s = '{BID: 4'h1, BRESP: 2'b00, BVALID: 1'b1};
    #3;
    check("b_dn_ready", 64'(dn_b_m.BREADY), 64'h1);
    next_cycle();
    dn_b_s = '{BID: 4'h2, BRESP: 2'b10, BVALID: 1'b1};
    #3;
    check("b_first", 64'({up_b_s.BVALID, up_b_s.BID}), 64'h11);
    next_cycle();
    dn_b_s.BVALID = 1'b0;
    rst_n = 1'b0;
    #3;
    check("b_full_held", 64'({up_b_s.BVALID, up_b_s.BID, up_b_s.BRESP, dn_b_m.BREADY}), 64'b1_0001_00_0);
    check("b_state_two", 64'(dbg_state[CH_B]), 64'(SKID_TWO));
    next_cycle();
    rst_n = 1'b1;
    up_b_m.BREADY = 1'b1;
    #3;
    check("b_after_rst_valid", 64'(up_b_s.BVALID), 64'h0);
    check("b_after_rst_ready", 64'(dn_b_m.BREADY), 64'h0);
    check("b_after_rst_state", 64'(dbg_state[CH_B]), 64'(SKID_EMPTY));
    next_cycle();
    #3;
    check("b_post_valid", 64'(up_b_s.BVALID), 64'h0);
    check("b_post_ready", 64'(dn_b_m.BREADY), 64'h1);

    // AW_EN=0: address and ready pass through with no clock edge in between.
    next_cycle();
    pt_up_aw_m.AWVALID = 1'b1;
    pt_up_aw_m.AWADDR  = 32'h1000_0040;
    pt_up_aw_m.AWID    = 4'hA;
    pt_dn_aw_s.AWREADY = 1'b0;
    #2;
    check("pt_aw_fwd", 64'({pt_dn_aw_m.AWVALID, pt_dn_aw_m.AWID, pt_dn_aw_m.AWADDR}), {27'h0, 1'b1, 4'hA, 32'h1000_0040});
    check("pt_aw_ready0", 64'(pt_up_aw_s.AWREADY), 64'h0);
    pt_dn_aw_s.AWREADY = 1'b1;
    #1;
    check("pt_aw_ready1", 64'(pt_up_aw_s.AWREADY), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
